// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
package load_store_unit_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  // RV32I load/store width and sign encodings (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, alignment/legality checks,
// store-data replication and load-data extraction with extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  data_t      wdata,
  input  data_t      mem_rd,
  output logic [3:0] be,
  output logic       misaligned,
  output logic       illegal,
  output data_t      wd,
  output data_t      rdata_ext
);

  data_t lane_s;

  // Decode width from funct3; misaligned is only meaningful for a legal access
  always_comb begin
    lane_s     = mem_rd >> {addr_lo, 3'b000};
    be         = 4'b0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    wd         = wdata;
    rdata_ext  = 32'h0000_0000;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wd        = {4{wdata[7:0]}};
        rdata_ext = {{24{lane_s[7]}}, lane_s[7:0]};
      end
      F3_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wd         = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        rdata_ext  = {{16{lane_s[15]}}, lane_s[15:0]};
      end
      F3_W: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
        rdata_ext  = lane_s;
      end
      F3_BU: begin
        be        = 4'b0001 << addr_lo;
        illegal   = we;
        rdata_ext = {24'h00_0000, lane_s[7:0]};
      end
      F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        illegal    = we;
        misaligned = addr_lo[0] & ~we;
        rdata_ext  = {16'h0000, lane_s[15:0]};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request, drives the data-memory port,
// waits (bounded by TIMEOUT) for completion and returns one response pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  addr_t       i_addr,
  input  data_t       i_wdata,
  output logic        o_rsp_valid,
  output data_t       o_rdata,
  output logic        o_misaligned,
  output logic        o_fault,
  output addr_t       o_mem_addr,
  output data_t       o_mem_wd,
  output logic [3:0]  o_mem_be,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  input  data_t       i_mem_rd,
  input  logic        i_mem_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             we_r, we_nxt_s;
  logic [2:0]       funct3_r, funct3_nxt_s;
  logic [1:0]       addr_lo_r, addr_lo_nxt_s;
  logic             req_ready_r, req_ready_nxt_s;
  logic             rsp_valid_r, rsp_valid_nxt_s;
  data_t            rdata_r, rdata_nxt_s;
  logic             misaligned_r, misaligned_nxt_s;
  logic             fault_r, fault_nxt_s;
  addr_t            mem_addr_r, mem_addr_nxt_s;
  data_t            mem_wd_r, mem_wd_nxt_s;
  logic [3:0]       mem_be_r, mem_be_nxt_s;
  logic             mem_wen_r, mem_wen_nxt_s;
  logic             mem_ren_r, mem_ren_nxt_s;

  logic             al_we_s;
  logic [2:0]       al_funct3_s;
  logic [1:0]       al_addr_lo_s;
  logic [3:0]       al_be_s;
  logic             al_misaligned_s;
  logic             al_illegal_s;
  data_t            al_wd_s;
  data_t            al_rdata_s;

  // Lane logic sees the live request in IDLE and the captured request afterwards
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_we_s      = i_we;
      al_funct3_s  = i_funct3;
      al_addr_lo_s = i_addr[1:0];
    end else begin
      al_we_s      = we_r;
      al_funct3_s  = funct3_r;
      al_addr_lo_s = addr_lo_r;
    end
  end

  lsu_align u_align (
    .we         (al_we_s),
    .funct3     (al_funct3_s),
    .addr_lo    (al_addr_lo_s),
    .wdata      (i_wdata),
    .mem_rd     (i_mem_rd),
    .be         (al_be_s),
    .misaligned (al_misaligned_s),
    .illegal    (al_illegal_s),
    .wd         (al_wd_s),
    .rdata_ext  (al_rdata_s)
  );

  // Next-state and next-output logic; every output register defaults to idle/zero
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    we_nxt_s         = we_r;
    funct3_nxt_s     = funct3_r;
    addr_lo_nxt_s    = addr_lo_r;
    req_ready_nxt_s  = 1'b0;
    rsp_valid_nxt_s  = 1'b0;
    rdata_nxt_s      = 32'h0000_0000;
    misaligned_nxt_s = 1'b0;
    fault_nxt_s      = 1'b0;
    mem_addr_nxt_s   = 32'h0000_0000;
    mem_wd_nxt_s     = 32'h0000_0000;
    mem_be_nxt_s     = 4'b0000;
    mem_wen_nxt_s    = 1'b0;
    mem_ren_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req_valid && req_ready_r) begin
          we_nxt_s      = i_we;
          funct3_nxt_s  = i_funct3;
          addr_lo_nxt_s = i_addr[1:0];
          if (al_illegal_s || al_misaligned_s) begin
            // Rejected without touching memory
            state_nxt_s      = ST_RESP;
            rsp_valid_nxt_s  = 1'b1;
            misaligned_nxt_s = al_misaligned_s;
            fault_nxt_s      = al_illegal_s;
          end else begin
            state_nxt_s    = ST_ACCESS;
            cnt_nxt_s      = {CNT_W{1'b0}};
            mem_addr_nxt_s = {i_addr[31:2], 2'b00};
            mem_wd_nxt_s   = al_wd_s;
            mem_be_nxt_s   = al_be_s;
            mem_ren_nxt_s  = ~i_we;
            mem_wen_nxt_s  = i_we;
          end
        end else begin
          req_ready_nxt_s = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (i_mem_ready) begin
          state_nxt_s     = ST_RESP;
          rsp_valid_nxt_s = 1'b1;
          rdata_nxt_s     = we_r ? 32'h0000_0000 : al_rdata_s;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s     = ST_RESP;
          rsp_valid_nxt_s = 1'b1;
          fault_nxt_s     = 1'b1;
        end else begin
          // Keep the memory port stable while waiting
          cnt_nxt_s      = cnt_r + CNT_ONE;
          mem_addr_nxt_s = mem_addr_r;
          mem_wd_nxt_s   = mem_wd_r;
          mem_be_nxt_s   = mem_be_r;
          mem_wen_nxt_s  = mem_wen_r;
          mem_ren_nxt_s  = mem_ren_r;
        end
      end
      ST_RESP: begin
        state_nxt_s     = ST_IDLE;
        req_ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        req_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // State, captured request and registered outputs; reset aborts any access
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      misaligned_r <= 1'b0;
      fault_r      <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wd_r     <= 32'h0000_0000;
      mem_be_r     <= 4'b0000;
      mem_wen_r    <= 1'b0;
      mem_ren_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      we_r         <= we_nxt_s;
      funct3_r     <= funct3_nxt_s;
      addr_lo_r    <= addr_lo_nxt_s;
      req_ready_r  <= req_ready_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rdata_r      <= rdata_nxt_s;
      misaligned_r <= misaligned_nxt_s;
      fault_r      <= fault_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wd_r     <= mem_wd_nxt_s;
      mem_be_r     <= mem_be_nxt_s;
      mem_wen_r    <= mem_wen_nxt_s;
      mem_ren_r    <= mem_ren_nxt_s;
    end
  end

  assign o_req_ready  = req_ready_r;
  assign o_rsp_valid  = rsp_valid_r;
  assign o_rdata      = rdata_r;
  assign o_misaligned = misaligned_r;
  assign o_fault      = fault_r;
  assign o_mem_addr   = mem_addr_r;
  assign o_mem_wd     = mem_wd_r;
  assign o_mem_be     = mem_be_r;
  assign o_mem_wen    = mem_wen_r;
  assign o_mem_ren    = mem_ren_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a timeline-based
// reference model: each accepted request predicts its access window and response cycle.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;
  localparam int NITER   = 2500;

  logic        i_clk, i_rst, i_req_valid, i_we, i_mem_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_mem_rd;
  logic        o_req_ready, o_rsp_valid, o_misaligned, o_fault, o_mem_wen, o_mem_ren;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wd;
  logic [3:0]  o_mem_be;

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_fault(o_fault),
    .o_mem_addr(o_mem_addr), .o_mem_wd(o_mem_wd), .o_mem_be(o_mem_be),
    .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .i_mem_rd(i_mem_rd), .i_mem_ready(i_mem_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int m_width(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] a);
    return (int'(a) % m_width(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] v;
    v = ((32'd1 << m_width(f3)) - 32'd1) << a;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wdata);
    case (m_width(f3))
      1:       return {24'h0, wdata[7:0]} * 32'h0101_0101;
      2:       return {16'h0, wdata[15:0]} * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * a);
    case (f3)
      3'd0:    return v[7]  ? ((v & 32'hFF)   | 32'hFFFF_FF00) : (v & 32'hFF);
      3'd4:    return v & 32'hFF;
      3'd1:    return v[15] ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      3'd5:    return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;      // access cycle (1-based) in which memory answers; > TIMEOUT = never
    logic [31:0] word;
  } req_t;

  function automatic req_t rand_req();
    req_t r;
    int   sel;
    r.we = 1'($urandom_range(0, 1));
    sel  = int'($urandom_range(0, 9));
    case (sel)
      0, 1:    r.f3 = 3'd0;
      2, 3:    r.f3 = 3'd1;
      4, 5:    r.f3 = 3'd2;
      6:       r.f3 = 3'd4;
      7:       r.f3 = 3'd5;
      default: r.f3 = 3'($urandom_range(0, 7));
    endcase
    r.addr = $urandom;
    if ($urandom_range(0, 1) == 0) r.addr[1:0] = 2'b00;
    r.wdata = $urandom;
    r.word  = $urandom;
    sel = int'($urandom_range(0, 19));
    if (sel < 14)      r.k = 1 + int'($urandom_range(0, 3));
    else if (sel < 16) r.k = TIMEOUT;
    else               r.k = TIMEOUT + 1 + int'($urandom_range(0, 3));
    return r;
  endfunction

  // ---------------- model state (written by stimulus, read by compare) ----------------
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_rsp, exp_str;
  logic [31:0] r_rdata, a_addr, a_wd, mem_word;
  logic        r_mis, r_fault, a_ren, a_wen;
  logic [3:0]  a_be;
  int          n = 0;
  int          acc_lo = -1, acc_hi = -1, resp_iv = -1, rdy_iv = -1;
  int          to_lo = -1, to_hi = -1, to_wen_cnt = 0;

  // Per-cycle compare against the model expectations
  initial begin
    forever begin
      @(negedge i_clk);
      if (chk_en) begin
        chk1("req_ready", o_req_ready, exp_ready);
        chk1("rsp_valid", o_rsp_valid, exp_rsp);
        if (exp_rsp) begin
          chk32("rdata", o_rdata, r_rdata);
          chk1("misaligned", o_misaligned, r_mis);
          chk1("fault", o_fault, r_fault);
        end else begin
          chk32("rdata_idle", o_rdata, 32'h0);
          chk1("misaligned_idle", o_misaligned, 1'b0);
          chk1("fault_idle", o_fault, 1'b0);
        end
        chk1("mem_ren", o_mem_ren, exp_str & a_ren);
        chk1("mem_wen", o_mem_wen, exp_str & a_wen);
        if (exp_str) begin
          chk32("mem_addr", o_mem_addr, a_addr);
          chk32("mem_be", {28'h0, o_mem_be}, {28'h0, a_be});
          if (a_wen) chk32("mem_wd", o_mem_wd, a_wd);
        end
        if (n >= to_lo && n <= to_hi && o_mem_wen) to_wen_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  req_t dir_q[$];
  req_t cur;
  int   di = 0;
  logic have, is_dir, rst_done = 1'b0;

  task automatic plan(input req_t r, input int now);
    logic legal, mis;
    int   m;
    legal = m_legal(r.we, r.f3);
    mis   = legal && m_mis(r.f3, r.addr[1:0]);
    if (!legal || mis) begin
      resp_iv = now + 1; acc_lo = -1; acc_hi = -1; rdy_iv = -1;
      r_rdata = 32'h0; r_mis = mis; r_fault = !legal;
    end else begin
      m       = (r.k <= TIMEOUT) ? r.k : TIMEOUT;
      acc_lo  = now + 1;
      acc_hi  = now + m;
      resp_iv = now + m + 1;
      rdy_iv  = (r.k <= TIMEOUT) ? now + r.k : -1;
      a_addr  = {r.addr[31:2], 2'b00};
      a_be    = m_be(r.f3, r.addr[1:0]);
      a_wd    = m_wd(r.f3, r.wdata);
      a_ren   = !r.we;
      a_wen   = r.we;
      mem_word = r.word;
      r_rdata = (r.k <= TIMEOUT && !r.we) ? m_ext(r.f3, r.addr[1:0], r.word) : 32'h0;
      r_mis   = 1'b0;
      r_fault = (r.k > TIMEOUT);
    end
  endtask

  initial begin
    // Hand-computed expectations that pin the model itself
    chk32("pin_lb_ext",  m_ext(3'd0, 2'd3, 32'h80FF_0000), 32'hFFFF_FF80);
    chk32("pin_lbu_ext", m_ext(3'd4, 2'd3, 32'h80FF_0000), 32'h0000_0080);
    chk32("pin_lb_be",   {28'h0, m_be(3'd0, 2'd3)}, 32'h8);
    chk32("pin_sh_wd",   m_wd(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk32("pin_sh_be",   {28'h0, m_be(3'd1, 2'd2)}, 32'hC);
    chk32("pin_lw_be",   {28'h0, m_be(3'd2, 2'd0)}, 32'hF);
    chk1("pin_lw_mis",   m_mis(3'd2, 2'd1), 1'b1);
    chk1("pin_su_illegal", m_legal(1'b1, 3'd4), 1'b0);

    dir_q.push_back('{we:1'b0, f3:3'd2, addr:32'h10, wdata:32'h0, k:1, word:32'hDEAD_BEEF});
    dir_q.push_back('{we:1'b0, f3:3'd0, addr:32'h13, wdata:32'h0, k:1, word:32'h80FF_0000});
    dir_q.push_back('{we:1'b0, f3:3'd4, addr:32'h13, wdata:32'h0, k:2, word:32'h80FF_0000});
    dir_q.push_back('{we:1'b1, f3:3'd1, addr:32'h22, wdata:32'h1234_ABCD, k:3, word:32'h0});
    dir_q.push_back('{we:1'b0, f3:3'd2, addr:32'h05, wdata:32'h0, k:1, word:32'h0});
    dir_q.push_back('{we:1'b1, f3:3'd2, addr:32'h40, wdata:32'h5555_AAAA, k:TIMEOUT + 5, word:32'h0});

    i_rst = 1'b1; i_req_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
    i_addr = 32'h0; i_wdata = 32'h0; i_mem_rd = 32'h0; i_mem_ready = 1'b0;
    exp_ready = 1'b1; exp_rsp = 1'b0; exp_str = 1'b0;
    a_ren = 1'b0; a_wen = 1'b0;
    #2;
    chk32("rst_mem_addr", o_mem_addr, 32'h0);
    chk32("rst_mem_wd", o_mem_wd, 32'h0);
    chk32("rst_mem_be", {28'h0, o_mem_be}, 32'h0);
    chk_en = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    for (int it = 0; it < NITER; it++) begin
      @(posedge i_clk);
      #1;
      n++;
      // Asynchronous reset pulse in the middle of an access window
      if (!rst_done && it > 400 && n >= acc_lo && n < acc_hi) begin
        i_req_valid = 1'b0; i_mem_ready = 1'b0;
        exp_ready = 1'b1; exp_rsp = 1'b0; exp_str = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        chk1("rst_async_ren", o_mem_ren, 1'b0);
        chk1("rst_async_wen", o_mem_wen, 1'b0);
        chk1("rst_async_ready", o_req_ready, 1'b1);
        chk1("rst_async_rsp", o_rsp_valid, 1'b0);
        #1 i_rst = 1'b0;
        acc_lo = -1; acc_hi = -1; resp_iv = -1; rdy_iv = -1;
        rst_done = 1'b1;
        continue;
      end
      if (n > resp_iv) begin
        exp_ready = 1'b1;
        have = 1'b0; is_dir = 1'b0;
        if (di < dir_q.size()) begin
          cur = dir_q[di]; di++; have = 1'b1; is_dir = 1'b1;
        end else if ($urandom_range(0, 9) < 8) begin
          cur = rand_req(); have = 1'b1;
        end
        if (have) begin
          i_req_valid = 1'b1; i_we = cur.we; i_funct3 = cur.f3;
          i_addr = cur.addr; i_wdata = cur.wdata;
          plan(cur, n);
          if (is_dir && cur.k > TIMEOUT) begin
            to_lo = n + 1; to_hi = n + TIMEOUT + 1;
          end
        end else begin
          i_req_valid = 1'b0; i_we = 1'($urandom_range(0, 1));
          i_funct3 = 3'($urandom_range(0, 7)); i_addr = $urandom; i_wdata = $urandom;
        end
      end else begin
        // Busy: requests (held or garbage) must be ignored
        exp_ready   = 1'b0;
        i_req_valid = 1'($urandom_range(0, 1));
        i_we = 1'($urandom_range(0, 1)); i_funct3 = 3'($urandom_range(0, 7));
        i_addr = $urandom; i_wdata = $urandom;
      end
      exp_str = (n >= acc_lo && n <= acc_hi);
      exp_rsp = (n == resp_iv);
      if (n == rdy_iv) begin
        i_mem_ready = 1'b1; i_mem_rd = mem_word;
      end else if (exp_str) begin
        i_mem_ready = 1'b0; i_mem_rd = $urandom;
      end else begin
        i_mem_ready = 1'($urandom_range(0, 1)); i_mem_rd = $urandom;
      end
    end
    @(negedge i_clk);
    chk32("timeout_wen_cycles", to_wen_cnt, 32'd16);
    chk1("rst_pulse_seen", rst_done, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
